// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, stall/flush generation and mult/div sequencer.
// Forwarding paths are present only when HAZARD_FWD_EN is defined; otherwise RAW hazards stall.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       jumpD,
  input  logic       pcsrcD,
  input  logic       mdstartD,
  input  logic       mfhiloD,
  input  logic       mdstartE,
  input  logic       mddivE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       md_busy,
  output logic       md_done
);

  localparam int unsigned CntW = $clog2(DIV_LAT) + 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

  typedef enum logic {StIdle, StBusy} md_state_e;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic lwstall, brstall, mdstall, rawstall, stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
    return we & (src != 5'd0) & (src == dst);
  endfunction

  function automatic logic br_conflict(input logic [4:0] src);
    return hit(src, writeregE, regwriteE) | hit(src, writeregM, memtoregM);
  endfunction

`ifdef HAZARD_FWD_EN
  always_comb begin
    forwardAE = 2'b00;
    if (hit(rsE, writeregM, regwriteM))      forwardAE = 2'b10;
    else if (hit(rsE, writeregW, regwriteW)) forwardAE = 2'b01;
    forwardBE = 2'b00;
    if (hit(rtE, writeregM, regwriteM))      forwardBE = 2'b10;
    else if (hit(rtE, writeregW, regwriteW)) forwardBE = 2'b01;
  end

  assign forwardAD = hit(rsD, writeregM, regwriteM);
  assign forwardBD = hit(rtD, writeregM, regwriteM);
  assign rawstall  = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rsE, rtE};

  assign forwardAE = 2'b00;
  assign forwardBE = 2'b00;
  assign forwardAD = 1'b0;
  assign forwardBD = 1'b0;
  // Without bypasses a consumer waits in D until its producer has left W.
  assign rawstall  = hit(rsD, writeregE, regwriteE) | hit(rtD, writeregE, regwriteE) |
                     hit(rsD, writeregM, regwriteM) | hit(rtD, writeregM, regwriteM) |
                     hit(rsD, writeregW, regwriteW) | hit(rtD, writeregW, regwriteW);
`endif

  assign lwstall = memtoregE & (writeregE != 5'd0) & ((writeregE == rsD) | (writeregE == rtD));
  assign brstall = (branchD & (br_conflict(rsD) | br_conflict(rtD))) | (jrD & br_conflict(rsD));
  assign mdstall = md_busy & (mdstartD | mfhiloD);
  assign stall   = lwstall | brstall | mdstall | rawstall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = (pcsrcD | jumpD | jrD) & ~stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mdstartE) begin
          cnt_d   = mddivE ? DivLoad : MulLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        else             state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy = (state_q == StBusy);
  assign md_done = md_busy & (cnt_q == '0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational vector table plus mult/div and load-use
// sequences. Expectations adapt to whether HAZARD_FWD_EN is defined.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, jumpD, pcsrcD, mdstartD, mfhiloD, mdstartE, mddivE;
  logic       forwardAD, forwardBD, stallF, stallD, flushD, flushE, md_busy, md_done;
  logic [1:0] forwardAE, forwardBE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .jrD(jrD),
    .jumpD(jumpD), .pcsrcD(pcsrcD), .mdstartD(mdstartD), .mfhiloD(mfhiloD),
    .mdstartE(mdstartE), .mddivE(mddivE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .md_busy(md_busy), .md_done(md_done)
  );

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD, jrD, jmpD, pcD;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD;
    logic       stl_f, stl_n, fl_f, fl_n;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; jrD = 0; jumpD = 0; pcsrcD = 0; mdstartD = 0; mfhiloD = 0;
    mdstartE = 0; mddivE = 0;
  endtask

  task automatic apply(input vec_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.wrE; writeregM = v.wrM; writeregW = v.wrW;
    regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
    memtoregE = v.mtrE; memtoregM = v.mtrM;
    branchD = v.brD; jrD = v.jrD; jumpD = v.jmpD; pcsrcD = v.pcD;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".stallF"}, 32'(stallF), 32'(exp));
    chk({name, ".stallD"}, 32'(stallD), 32'(exp));
    chk({name, ".flushE"}, 32'(flushE), 32'(exp));
  endtask

  initial begin
    vec_t z;
    int   done_cnt;
    int   busy_cnt;
    z = '{default: '0};
    for (int i = 0; i < 18; i++) tbl[i] = z;
    // Forward priority on A and B operands
    tbl[1].rsE = 5; tbl[1].wrM = 5; tbl[1].rwM = 1; tbl[1].wrW = 5; tbl[1].rwW = 1;
    tbl[1].fAE = 2'b10;
    tbl[2] = tbl[1]; tbl[2].rwM = 0; tbl[2].fAE = 2'b01;
    tbl[3] = tbl[1]; tbl[3].rsE = 0; tbl[3].fAE = 2'b00;
    tbl[4].rtE = 7; tbl[4].wrM = 7; tbl[4].rwM = 1; tbl[4].fBE = 2'b10;
    tbl[5].rtE = 7; tbl[5].wrM = 7; tbl[5].wrW = 7; tbl[5].rwW = 1; tbl[5].fBE = 2'b01;
    // Load-use, with and without a taken branch
    tbl[6].mtrE = 1; tbl[6].wrE = 8; tbl[6].rwE = 1; tbl[6].rtD = 8;
    tbl[6].stl_f = 1; tbl[6].stl_n = 1;
    tbl[7] = tbl[6]; tbl[7].pcD = 1;
    // Branch dependencies
    tbl[8].brD = 1; tbl[8].rsD = 3; tbl[8].rwE = 1; tbl[8].wrE = 3;
    tbl[8].stl_f = 1; tbl[8].stl_n = 1;
    tbl[9].brD = 1; tbl[9].rsD = 3; tbl[9].wrM = 3; tbl[9].rwM = 1;
    tbl[9].fAD = 1; tbl[9].stl_n = 1;
    tbl[10] = tbl[9]; tbl[10].pcD = 1; tbl[10].fl_f = 1;
    tbl[11].brD = 1; tbl[11].rtD = 9; tbl[11].wrM = 9; tbl[11].mtrM = 1; tbl[11].rwM = 1;
    tbl[11].fBD = 1; tbl[11].stl_f = 1; tbl[11].stl_n = 1;
    tbl[12].jrD = 1; tbl[12].rtD = 6; tbl[12].rwE = 1; tbl[12].wrE = 6;
    tbl[12].fl_f = 1; tbl[12].stl_n = 1;
    tbl[13].jmpD = 1; tbl[13].fl_f = 1; tbl[13].fl_n = 1;
    // RAW without bypass paths, register 0, and a W-stage producer
    tbl[14].rsD = 4; tbl[14].wrM = 4; tbl[14].rwM = 1; tbl[14].fAD = 1; tbl[14].stl_n = 1;
    tbl[15].mtrE = 1; tbl[15].rwE = 1; tbl[15].rwM = 1; tbl[15].brD = 1;
    tbl[16].rsD = 2; tbl[16].wrW = 2; tbl[16].rwW = 1; tbl[16].stl_n = 1;
    tbl[17].mtrE = 1; tbl[17].wrE = 10; tbl[17].rsD = 10; tbl[17].stl_f = 1; tbl[17].stl_n = 1;

    clr();
    reset = 1'b1;
    apply(tbl[6]);
    tick();
    chk("rst.md_busy", 32'(md_busy), 32'd0);
    chk("rst.md_done", 32'(md_done), 32'd0);
    chk_stall("rst.lwstall", 1'b1);
    tick();
    reset = 1'b0;
    clr();
    tick();

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d.fAE", i), 32'(forwardAE), 32'(FwdEn ? tbl[i].fAE : 2'b00));
      chk($sformatf("v%0d.fBE", i), 32'(forwardBE), 32'(FwdEn ? tbl[i].fBE : 2'b00));
      chk($sformatf("v%0d.fAD", i), 32'(forwardAD), 32'(FwdEn ? tbl[i].fAD : 1'b0));
      chk($sformatf("v%0d.fBD", i), 32'(forwardBD), 32'(FwdEn ? tbl[i].fBD : 1'b0));
      chk_stall($sformatf("v%0d", i), FwdEn ? tbl[i].stl_f : tbl[i].stl_n);
      chk($sformatf("v%0d.flushD", i), 32'(flushD), 32'(FwdEn ? tbl[i].fl_f : tbl[i].fl_n));
    end

    // Load-use across three cycles: stall once, then W forward to the consumer
    clr(); tick();
    memtoregE = 1; writeregE = 8; regwriteE = 1; rtD = 8; #1;
    chk_stall("lu.c0", 1'b1);
    tick();
    clr(); memtoregM = 1; writeregM = 8; regwriteM = 1; rtD = 8; #1;
    chk_stall("lu.c1", !FwdEn);
    tick();
    clr(); rtE = 8; writeregW = 8; regwriteW = 1; #1;
    chk("lu.c2.fBE", 32'(forwardBE), 32'(FwdEn ? 2'b01 : 2'b00));
    chk_stall("lu.c2", 1'b0);

    // Multiply: start in N, busy N+1..N+4, done N+4, dependent mfhi from N+2;
    // a start request while busy (N+2) must be ignored.
    clr(); tick();
    mdstartE = 1; mddivE = 0; #1;
    chk("mul.n0.busy", 32'(md_busy), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      mdstartE = (k == 2);
      mfhiloD  = (k >= 2);
      #1;
      chk($sformatf("mul.n%0d.busy", k), 32'(md_busy), 32'(k <= 4));
      chk($sformatf("mul.n%0d.done", k), 32'(md_done), 32'(k == 4));
      chk_stall($sformatf("mul.n%0d", k), (k >= 2) && (k <= 4));
    end

    // Full divide: busy for 32 cycles, a single done pulse in the last one
    clr(); tick();
    mdstartE = 1; mddivE = 1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      mdstartE = 0;
      #1;
      busy_cnt += int'(md_busy);
      done_cnt += int'(md_done);
      if (k == 32) chk("div.done_at_32", 32'(md_done), 32'd1);
    end
    chk("div.busy_cycles", 32'(busy_cnt), 32'd32);
    chk("div.done_pulses", 32'(done_cnt), 32'd1);

    // Divide aborted by reset in the 10th busy cycle
    clr(); tick();
    mdstartE = 1; mddivE = 1;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      mdstartE = 0;
      reset    = (k == 10);
      #1;
      done_cnt += int'(md_done);
      if (k == 10) chk("divrst.busy_k10", 32'(md_busy), 32'd1);
      if (k == 11) chk("divrst.busy_k11", 32'(md_busy), 32'd0);
    end
    chk("divrst.done_pulses", 32'(done_cnt), 32'd0);
    chk("divrst.busy_end", 32'(md_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
